// File: rtl/board_loader_pkg.sv
// Shared constants and types for the board loader: piece codes, error codes,
// castle-bit positions and the loader FSM state type.
package board_loader_pkg;

    localparam int PIECE_WIDTH = 4;
    localparam int ROW_WIDTH   = PIECE_WIDTH * 8;
    localparam int BOARD_WIDTH = PIECE_WIDTH * 64;

    localparam logic [PIECE_WIDTH-1:0] PIECE_EMPTY = 4'd0;
    localparam logic [PIECE_WIDTH-1:0] WHITE_KING  = 4'd6;
    localparam logic [PIECE_WIDTH-1:0] BLACK_KING  = 4'd14;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SHORT = 2'd1;
    localparam logic [1:0] ERR_LONG  = 2'd2;
    localparam logic [1:0] ERR_KINGS = 2'd3;

    localparam int CASTLE_WK = 0;
    localparam int CASTLE_WQ = 1;
    localparam int CASTLE_BK = 2;
    localparam int CASTLE_BQ = 3;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    // Two-bit counter that sticks at 3 so a flood of kings cannot wrap back to 1.
    function automatic logic [1:0] sat_inc(input logic [1:0] cnt, input logic hit);
        logic [1:0] res;
        if (hit && (cnt != 2'd3)) begin
            res = cnt + 2'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/board_loader_if.sv
// Square stream in, packed board plus metadata out; the loader uses the slave view.
interface board_loader_if;
    import board_loader_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [PIECE_WIDTH-1:0] in_piece;
    logic                   in_last;
    logic                   in_white_to_move;
    logic [3:0]             in_castle_mask;
    logic [3:0]             in_en_passant_col;
    logic [BOARD_WIDTH-1:0] board;
    logic                   white_to_move;
    logic [3:0]             castle_mask;
    logic [3:0]             en_passant_col;
    logic                   board_valid;
    logic                   board_ready;
    logic                   load_error;
    logic [1:0]             error_code;

    modport master (
        output in_valid, in_piece, in_last, in_white_to_move, in_castle_mask,
               in_en_passant_col, board_ready,
        input  in_ready, board, white_to_move, castle_mask, en_passant_col,
               board_valid, load_error, error_code
    );

    modport slave (
        input  in_valid, in_piece, in_last, in_white_to_move, in_castle_mask,
               in_en_passant_col, board_ready,
        output in_ready, board, white_to_move, castle_mask, en_passant_col,
               board_valid, load_error, error_code
    );

endinterface

// File: rtl/board_loader.sv
// Assembles a 64-square position into a shadow board, validates it, and hands
// it to a double-buffered output slot over a valid/ready handshake.
module board_loader
    import board_loader_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    board_loader_if.slave bus
);

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [5:0]             sq_count_r;
    logic [1:0]             wk_cnt_r;
    logic [1:0]             bk_cnt_r;
    logic [1:0]             wk_inc_s;
    logic [1:0]             bk_inc_s;
    logic [BOARD_WIDTH-1:0] shadow_r;
    logic [BOARD_WIDTH-1:0] board_r;
    logic                   pend_wtm_r;
    logic [3:0]             pend_castle_r;
    logic [3:0]             pend_ep_r;
    logic                   wtm_r;
    logic [3:0]             castle_r;
    logic [3:0]             ep_r;
    logic                   board_valid_r;
    logic                   in_ready_r;
    logic                   load_error_r;
    logic [1:0]             error_code_r;
    logic                   accept_s;
    logic                   discard_s;
    logic                   transfer_s;
    logic [1:0]             err_s;

    // King tallies as they would stand after the current beat.
    assign wk_inc_s = sat_inc(wk_cnt_r, bus.in_piece == WHITE_KING);
    assign bk_inc_s = sat_inc(bk_cnt_r, bus.in_piece == BLACK_KING);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state, beat acceptance, discard classification and transfer decision.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        discard_s  = 1'b0;
        transfer_s = 1'b0;
        err_s      = ERR_NONE;
        case (state_r)
            ST_FILL: begin
                accept_s = bus.in_valid;
                if (accept_s && bus.in_last && (sq_count_r != 6'd63)) begin
                    discard_s = 1'b1;
                    err_s     = ERR_SHORT;
                end else if (accept_s && (sq_count_r == 6'd63) && !bus.in_last) begin
                    discard_s = 1'b1;
                    err_s     = ERR_LONG;
                end else if (accept_s && (sq_count_r == 6'd63)) begin
                    if ((wk_inc_s == 2'd1) && (bk_inc_s == 2'd1)) begin
                        state_nx_s = ST_PEND;
                    end else begin
                        discard_s = 1'b1;
                        err_s     = ERR_KINGS;
                    end
                end else begin
                    state_nx_s = ST_FILL;
                end
            end
            ST_PEND: begin
                transfer_s = !board_valid_r || bus.board_ready;
                if (transfer_s) begin
                    state_nx_s = ST_FILL;
                end else begin
                    state_nx_s = ST_PEND;
                end
            end
            default: begin
                state_nx_s = ST_FILL;
            end
        endcase
    end

    // Square index and king tallies; a discard or a transfer restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sq_count_r <= 6'd0;
            wk_cnt_r   <= 2'd0;
            bk_cnt_r   <= 2'd0;
        end else if (discard_s || transfer_s) begin
            sq_count_r <= 6'd0;
            wk_cnt_r   <= 2'd0;
            bk_cnt_r   <= 2'd0;
        end else if (accept_s) begin
            sq_count_r <= sq_count_r + 6'd1;
            wk_cnt_r   <= wk_inc_s;
            bk_cnt_r   <= bk_inc_s;
        end
    end

    // Shadow board write; discarded partial boards are simply overwritten later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_r <= '0;
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (accept_s && (sq_count_r == 6'(i))) begin
                    shadow_r[i*PIECE_WIDTH +: PIECE_WIDTH] <= bus.in_piece;
                end
            end
        end
    end

    // Metadata captured from the accepted, valid last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_wtm_r    <= 1'b0;
            pend_castle_r <= 4'd0;
            pend_ep_r     <= 4'd0;
        end else if (accept_s && (state_nx_s == ST_PEND)) begin
            pend_wtm_r    <= bus.in_white_to_move;
            pend_castle_r <= bus.in_castle_mask;
            pend_ep_r     <= bus.in_en_passant_col;
        end
    end

    // Output slot: a transfer wins over a consume so the slot never goes empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            board_r       <= '0;
            wtm_r         <= 1'b0;
            castle_r      <= 4'd0;
            ep_r          <= 4'd0;
            board_valid_r <= 1'b0;
        end else if (transfer_s) begin
            board_r       <= shadow_r;
            wtm_r         <= pend_wtm_r;
            castle_r      <= pend_castle_r;
            ep_r          <= pend_ep_r;
            board_valid_r <= 1'b1;
        end else if (board_valid_r && bus.board_ready) begin
            board_valid_r <= 1'b0;
        end
    end

    // Registered stream ready and error reporting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_r   <= 1'b1;
            load_error_r <= 1'b0;
            error_code_r <= ERR_NONE;
        end else begin
            in_ready_r   <= (state_nx_s == ST_FILL);
            load_error_r <= discard_s;
            if (discard_s) begin
                error_code_r <= err_s;
            end
        end
    end

    assign bus.in_ready       = in_ready_r;
    assign bus.board          = board_r;
    assign bus.white_to_move  = wtm_r;
    assign bus.castle_mask    = castle_r;
    assign bus.en_passant_col = ep_r;
    assign bus.board_valid    = board_valid_r;
    assign bus.load_error     = load_error_r;
    assign bus.error_code     = error_code_r;

endmodule

// File: tb/tb_board_loader.sv
// Directed-plus-random bench for board_loader, checked against a position-level model.
module tb_board_loader;
    import board_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   err_pulses = 0;

    logic [PIECE_WIDTH-1:0] pos [64];
    logic                   wtm_m;
    logic [3:0]             cm_m;
    logic [3:0]             ep_m;
    logic [BOARD_WIDTH-1:0] board_a;
    logic [8:0]             meta_a;
    int                     e0;

    board_loader_if bus ();

    board_loader dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.load_error === 1'b1) err_pulses++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BOARD_WIDTH-1:0] pack_board();
        logic [BOARD_WIDTH-1:0] b;
        b = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r*ROW_WIDTH + c*PIECE_WIDTH +: PIECE_WIDTH] = pos[r*8 + c];
        return b;
    endfunction

    // Outcome of a stream of n beats from pos[], with in_last on beat last_at (-1: none).
    function automatic logic [1:0] model_code(input int n, input int last_at);
        int wk;
        int bk;
        wk = 0;
        bk = 0;
        if (last_at >= 0 && last_at < 63) return ERR_SHORT;
        if (n == 64 && last_at != 63) return ERR_LONG;
        for (int i = 0; i < 64; i++) begin
            if (pos[i] == WHITE_KING) wk++;
            if (pos[i] == BLACK_KING) bk++;
        end
        return (wk == 1 && bk == 1) ? ERR_NONE : ERR_KINGS;
    endfunction

    task automatic gen_pos();
        logic [3:0] pool [13];
        int wk;
        int bk;
        pool = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13};
        for (int i = 0; i < 64; i++) pos[i] = pool[$urandom_range(0, 12)];
        wk = $urandom_range(0, 63);
        bk = (wk + 1 + $urandom_range(0, 62)) % 64;
        pos[wk] = WHITE_KING;
        pos[bk] = BLACK_KING;
        wtm_m = 1'($urandom);
        cm_m  = 4'($urandom);
        ep_m  = 4'($urandom);
    endtask

    task automatic start_pos();
        logic [3:0] back [8];
        back = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
        for (int i = 0; i < 64; i++) pos[i] = 4'd0;
        for (int c = 0; c < 8; c++) begin
            pos[c]      = back[c];
            pos[8 + c]  = 4'd1;
            pos[48 + c] = 4'd9;
            pos[56 + c] = back[c] + 4'd8;
        end
        wtm_m = 1'b1;
        cm_m  = 4'hF;
        ep_m  = 4'h0;
    endtask

    task automatic do_beat(input logic [3:0] p, input logic l);
        int t;
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid          = 1'b1;
        bus.in_piece          = p;
        bus.in_last           = l;
        bus.in_white_to_move  = l ? wtm_m : 1'($urandom);
        bus.in_castle_mask    = l ? cm_m  : 4'($urandom);
        bus.in_en_passant_col = l ? ep_m  : 4'($urandom);
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (bus.in_ready !== 1'b1) chk("beat_accept_timeout", 256'(bus.in_ready), 256'(1'b1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send(input int n, input int last_at);
        for (int i = 0; i < n; i++) do_beat(pos[i], (i == last_at));
    endtask

    task automatic check_deliver();
        @(negedge clk);
        chk("pend_in_ready", 256'(bus.in_ready), 256'(1'b0));
        chk("pend_valid", 256'(bus.board_valid), 256'(1'b0));
        @(negedge clk);
        chk("deliver_valid", 256'(bus.board_valid), 256'(1'b1));
        chk("deliver_board", 256'(bus.board), 256'(pack_board()));
        chk("deliver_meta", 256'({bus.white_to_move, bus.castle_mask, bus.en_passant_col}),
            256'({wtm_m, cm_m, ep_m}));
        chk("deliver_in_ready", 256'(bus.in_ready), 256'(1'b1));
    endtask

    task automatic check_discard(input logic [1:0] code);
        @(negedge clk);
        chk("discard_pulse", 256'(bus.load_error), 256'(1'b1));
        chk("discard_code", 256'(bus.error_code), 256'(code));
        chk("discard_no_valid", 256'(bus.board_valid), 256'(1'b0));
        @(negedge clk);
        chk("discard_pulse_end", 256'(bus.load_error), 256'(1'b0));
    endtask

    initial begin
        rst_n                 = 1'b0;
        bus.in_valid          = 1'b0;
        bus.in_piece          = 4'd0;
        bus.in_last           = 1'b0;
        bus.in_white_to_move  = 1'b0;
        bus.in_castle_mask    = 4'd0;
        bus.in_en_passant_col = 4'd0;
        bus.board_ready       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 256'(bus.in_ready), 256'(1'b1));
        chk("rst_board", 256'(bus.board), 256'(0));
        chk("rst_valid", 256'(bus.board_valid), 256'(1'b0));
        chk("rst_load_error", 256'(bus.load_error), 256'(1'b0));
        chk("rst_error_code", 256'(bus.error_code), 256'(ERR_NONE));
        chk("rst_meta", 256'({bus.white_to_move, bus.castle_mask, bus.en_passant_col}), 256'(0));

        // Start position, free output slot: two-cycle latency, no error.
        bus.board_ready = 1'b1;
        start_pos();
        e0 = err_pulses;
        send(64, 63);
        check_deliver();
        chk("start_castle_wk", 256'(bus.castle_mask[CASTLE_WK]), 256'(1'b1));
        @(negedge clk);
        chk("consumed_valid", 256'(bus.board_valid), 256'(1'b0));
        chk("start_no_error", 256'(err_pulses - e0), 256'(0));

        // Short stream, then a good load.
        gen_pos();
        send(41, 40);
        check_discard(model_code(41, 40));
        gen_pos();
        send(64, 63);
        check_deliver();

        // Long stream, then a good load.
        gen_pos();
        send(64, -1);
        check_discard(model_code(64, -1));
        gen_pos();
        send(64, 63);
        check_deliver();

        // Two white kings.
        gen_pos();
        for (int i = 0; i < 64; i++) begin
            if (pos[i] != WHITE_KING && pos[i] != BLACK_KING) begin
                pos[i] = WHITE_KING;
                break;
            end
        end
        send(64, 63);
        check_discard(model_code(64, 63));
        repeat (3) @(negedge clk);
        chk("kings_no_valid", 256'(bus.board_valid), 256'(1'b0));

        // Backpressure: A held while B fills and parks.
        bus.board_ready = 1'b0;
        @(negedge clk);
        gen_pos();
        send(64, 63);
        check_deliver();
        board_a = pack_board();
        meta_a  = {wtm_m, cm_m, ep_m};
        gen_pos();
        send(64, 63);
        @(negedge clk);
        chk("bp_in_ready_low", 256'(bus.in_ready), 256'(1'b0));
        repeat (3) @(negedge clk);
        chk("bp_hold_board", 256'(bus.board), 256'(board_a));
        chk("bp_hold_meta", 256'({bus.white_to_move, bus.castle_mask, bus.en_passant_col}),
            256'(meta_a));
        chk("bp_hold_valid", 256'(bus.board_valid), 256'(1'b1));
        chk("bp_still_parked", 256'(bus.in_ready), 256'(1'b0));
        bus.board_ready = 1'b1;
        @(negedge clk);
        bus.board_ready = 1'b0;
        chk("swap_valid", 256'(bus.board_valid), 256'(1'b1));
        chk("swap_board", 256'(bus.board), 256'(pack_board()));
        chk("swap_meta", 256'({bus.white_to_move, bus.castle_mask, bus.en_passant_col}),
            256'({wtm_m, cm_m, ep_m}));
        chk("swap_in_ready", 256'(bus.in_ready), 256'(1'b1));
        @(negedge clk);
        chk("swap_stable", 256'(bus.board), 256'(pack_board()));

        // Reset in the middle of a stream while B is still held.
        gen_pos();
        send(30, -1);
        @(negedge clk);
        e0 = err_pulses;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 256'(bus.in_ready), 256'(1'b1));
        chk("midrst_board", 256'(bus.board), 256'(0));
        chk("midrst_valid", 256'(bus.board_valid), 256'(1'b0));
        chk("midrst_error_code", 256'(bus.error_code), 256'(ERR_NONE));
        @(negedge clk);
        rst_n = 1'b1;
        bus.board_ready = 1'b1;
        gen_pos();
        send(64, 63);
        check_deliver();
        chk("midrst_no_pulse", 256'(err_pulses - e0), 256'(0));

        // A few random loads, some with illegal king counts.
        for (int n = 0; n < 4; n++) begin
            gen_pos();
            if (n[0]) pos[$urandom_range(0, 63)] = BLACK_KING;
            if (model_code(64, 63) == ERR_NONE) begin
                send(64, 63);
                check_deliver();
            end else begin
                send(64, 63);
                check_discard(model_code(64, 63));
            end
            repeat (2) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_loader.md
Name: board_loader

Overview:
- Upstream feeder for vchess: assembles a packed board from a square-by-square stream of pieces (host/bench side).
- Validates the assembled position and hands it downstream over a valid/ready handshake, together with side-to-move, castle rights and en-passant metadata.
- Double-buffered: a shadow board can be filled while the previous board is still held at the output.

Parameters:
- PIECE_WIDTH, `PIECE_BITS: bits per square.
- ROW_WIDTH, PIECE_WIDTH*8: bits per rank (derived).
- BOARD_WIDTH, PIECE_WIDTH*64: packed board width (derived).

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: stream beat valid.
- in_ready, output, 1: stream beat accepted when in_valid && in_ready.
- in_piece, input, PIECE_WIDTH: piece code for the current square.
- in_last, input, 1: marks the final beat of a position.
- in_white_to_move, input, 1: metadata, sampled on the accepted in_last beat.
- in_castle_mask, input, 4: metadata {BQ,BK,WQ,WK}, sampled on the accepted in_last beat.
- in_en_passant_col, input, 4: metadata; bit3 = valid, bits2:0 = column; sampled on the accepted in_last beat.
- board, output, BOARD_WIDTH: packed board; square (row,col) at bit row*ROW_WIDTH+col*PIECE_WIDTH.
- white_to_move, output, 1: output metadata.
- castle_mask, output, 4: output metadata.
- en_passant_col, output, 4: output metadata.
- board_valid, output, 1: output board valid.
- board_ready, input, 1: downstream accept.
- load_error, output, 1: one-cycle pulse when a position is discarded.
- error_code, output, 2: 0 none, 1 short (in_last before 64th beat), 2 long (64th beat without in_last), 3 king count; held until the next error.

Behaviour:
- Reset values: in_ready=1, board=0 (all squares empty), all metadata=0, board_valid=0, load_error=0, error_code=0, sq_count=0, shadow=0, king counters=0, state=FILL.
- Square order: beat k writes shadow square k (row=k[5:3], col=k[2:0]); k = sq_count, 6 bits.
- Per accepted beat:
  - shadow[k] <= in_piece; sq_count increments.
  - Separate 2-bit saturating counters track `WHITE_KING` and `BLACK_KING` codes.
- FILL state:
  - in_ready=1.
  - Accepted beat with in_last and sq_count<63: discard; load_error pulse next cycle; error_code=1; sq_count=0; counters cleared; stay FILL.
  - Accepted beat with sq_count==63 and !in_last: discard; error_code=2; same recovery as above.
  - Accepted beat with sq_count==63 and in_last:
    - If the king counts, including this beat, are not exactly one white and one black: error_code=3, discard.
    - Otherwise latch metadata, go to PEND.
  - The shadow need not be cleared on discard; every square is rewritten by the next load.
- PEND state:
  - in_ready=0.
  - Transfer shadow and metadata to the output registers when !board_valid || board_ready.
  - The transfer cycle sets board_valid=1, sq_count=0, counters=0, state=FILL.
  - in_ready returns to 1 the cycle after the transfer.
- Latency: with the output slot free, board_valid asserts 2 cycles after the accepted last beat: edge 1 enters PEND, edge 2 transfers.
- Output handshake:
  - board_valid && board_ready with no transfer in the same cycle: board_valid <= 0.
  - Simultaneous consume and transfer: board_valid stays 1 with the new board loaded.
  - Outputs are stable while board_valid && !board_ready.
- Backpressure: a new stream can fill while the output holds an unconsumed board. The following last beat parks in PEND until the output slot frees.
- in_valid while in_ready=0 is ignored; the data is not consumed.
- Reset asserted mid-stream or mid-PEND: all state returns to reset values immediately. The partial position is lost; no error pulse.
- error_code updates only on a discard; load_error is high for exactly one cycle per discard.

Decomposition:
- Constants in vchess.vh:
  - PIECE_BITS and the piece codes (`WHITE_KING`, `BLACK_KING`, empty=0).
  - New defines: ERR_NONE/ERR_SHORT/ERR_LONG/ERR_KINGS.
  - New defines: castle-bit positions CASTLE_WK=0, WK... (bit0 WK, bit1 WQ, bit2 BK, bit3 BQ).
- No sub-module is required; the king counting is a small inline always block.

Test Plan:
- Stream the standard start position (64 beats, in_last on beat 63, white_to_move=1, castle=4'hF, ep=0) with board_ready=1 -> board_valid 2 cycles later; board equals the tb initial layout; load_error never pulses.
- in_last on beat 40 -> load_error pulse, error_code=1, board_valid stays 0; the next full valid load succeeds.
- 64 beats without in_last, then 64 valid beats -> error_code=2 after beat 63, then the second load is delivered correctly.
- Position with two white kings -> error_code=3, no board_valid.
- board_ready=0; load A, then load B -> A held stable; in_ready drops after B's last beat. Raise board_ready for 1 cycle -> B appears the same cycle A is consumed; board_valid stays 1.
- Assert reset at beat 30 of a load -> in_ready=1, board=0, board_valid=0 immediately; the following full load is delivered with correct square indexing starting at square 0.
